// File: rtl/vc_dest_arbiter.sv
// Weighted round-robin drain of two virtual-channel FIFOs into destination FIFOs D0/D1.
// VC0 gets up to WEIGHT0 back-to-back grants while VC1 waits; each granted word is routed by its DEST_BIT.
module vc_dest_arbiter #(
  parameter int BW       = 6,
  parameter int DEST_BIT = 4,
  parameter int WEIGHT0  = 4
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          enable,
  input  logic          vc0_empty,
  input  logic          vc1_empty,
  input  logic [BW-1:0] vc0_data,
  input  logic [BW-1:0] vc1_data,
  input  logic          d0_almost_full,
  input  logic          d1_almost_full,
  output logic          vc0_pop,
  output logic          vc1_pop,
  output logic          d0_push,
  output logic          d1_push,
  output logic [BW-1:0] d0_data,
  output logic [BW-1:0] d1_data,
  output logic [7:0]    vc0_cnt,
  output logic [7:0]    vc1_cnt,
  output logic          arb_idle
);

  localparam logic [2:0] W0 = WEIGHT0[2:0];

  typedef enum logic {
    PREF0 = 1'b0,
    PREF1 = 1'b1
  } arb_state_t;

  arb_state_t    state;
  logic [2:0]    credit;
  logic [2:0]    credit_up;
  logic          elig0;
  logic          elig1;
  logic          pop0;
  logic          pop1;
  logic          any_pop;
  logic [BW-1:0] win_word;
  logic          win_dest;

  logic          push0_p1;
  logic          push1_p1;
  logic [BW-1:0] data0_p1;
  logic [BW-1:0] data1_p1;
  logic [7:0]    cnt0_p1;
  logic [7:0]    cnt1_p1;
  logic          idle_p1;

  // Saturate rather than wrap so a long VC1-ineligible run cannot restart VC0's quota.
  function automatic logic [2:0] credit_inc(input logic [2:0] c);
    return (c == 3'd7) ? 3'd7 : c + 3'd1;
  endfunction

  function automatic logic dest_af(input logic [BW-1:0] word, input logic af0, input logic af1);
    return word[DEST_BIT] ? af1 : af0;
  endfunction

  // Stage p0: eligibility and grant, decided combinationally from the show-ahead heads.
  always_comb begin
    elig0 = reset_L & enable & ~vc0_empty & ~dest_af(vc0_data, d0_almost_full, d1_almost_full);
    elig1 = reset_L & enable & ~vc1_empty & ~dest_af(vc1_data, d0_almost_full, d1_almost_full);
    if (state == PREF0) begin
      pop0 = elig0;
      pop1 = elig1 & ~elig0;
    end else begin
      pop0 = elig0 & ~elig1;
      pop1 = elig1;
    end
    any_pop   = pop0 | pop1;
    win_word  = pop1 ? vc1_data : vc0_data;
    win_dest  = win_word[DEST_BIT];
    credit_up = credit_inc(credit);
  end

  assign vc0_pop = pop0;
  assign vc1_pop = pop1;

  // With no grant both branches fall through, so state and credit hold on enable=0 or blocking.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state  <= PREF0;
      credit <= 3'd0;
    end else begin
      unique case (state)
        PREF0: begin
          if (pop0) begin
            credit <= credit_up;
            if ((credit_up >= W0) && elig1) state <= PREF1;
          end else if (pop1) begin
            credit <= 3'd0;
          end
        end
        PREF1: begin
          if (pop1) begin
            credit <= 3'd0;
            state  <= PREF0;
          end else if (pop0) begin
            credit <= 3'd1;
            state  <= PREF0;
          end
        end
        default: state <= PREF0;
      endcase
    end
  end

  // Stage p1: registered push toward the destination selected by the popped word.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      push0_p1 <= 1'b0;
      push1_p1 <= 1'b0;
      data0_p1 <= '0;
      data1_p1 <= '0;
      cnt0_p1  <= 8'd0;
      cnt1_p1  <= 8'd0;
      idle_p1  <= 1'b1;
    end else begin
      push0_p1 <= any_pop & ~win_dest;
      push1_p1 <= any_pop & win_dest;
      if (any_pop && !win_dest) data0_p1 <= win_word;
      if (any_pop && win_dest)  data1_p1 <= win_word;
      if (pop0) cnt0_p1 <= cnt0_p1 + 8'd1;
      if (pop1) cnt1_p1 <= cnt1_p1 + 8'd1;
      // A pop this cycle is the word in flight; idle only once both sources are drained.
      idle_p1  <= vc0_empty & vc1_empty & ~any_pop;
    end
  end

  assign d0_push  = push0_p1;
  assign d1_push  = push1_p1;
  assign d0_data  = data0_p1;
  assign d1_data  = data1_p1;
  assign vc0_cnt  = cnt0_p1;
  assign vc1_cnt  = cnt1_p1;
  assign arb_idle = idle_p1;

endmodule

// File: tb/tb_vc_dest_arbiter.sv
// Directed bench for vc_dest_arbiter: show-ahead VC FIFOs modelled as queues, expectations hand-derived.
module tb_vc_dest_arbiter;
  localparam int BW = 6;

  logic          clk = 1'b0;
  logic          reset_L;
  logic          enable;
  logic          vc0_empty, vc1_empty;
  logic [BW-1:0] vc0_data, vc1_data;
  logic          d0_af, d1_af;
  logic          vc0_pop, vc1_pop, d0_push, d1_push;
  logic [BW-1:0] d0_data, d1_data;
  logic [7:0]    vc0_cnt, vc1_cnt;
  logic          arb_idle;

  logic [BW-1:0] q0[$];
  logic [BW-1:0] q1[$];
  logic          obs_pop0, obs_pop1;
  int            n_cmp = 0;
  int            n_fail = 0;

  vc_dest_arbiter #(.BW(BW), .DEST_BIT(4), .WEIGHT0(4)) dut (
    .clk(clk), .reset_L(reset_L), .enable(enable),
    .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
    .vc0_data(vc0_data), .vc1_data(vc1_data),
    .d0_almost_full(d0_af), .d1_almost_full(d1_af),
    .vc0_pop(vc0_pop), .vc1_pop(vc1_pop),
    .d0_push(d0_push), .d1_push(d1_push),
    .d0_data(d0_data), .d1_data(d1_data),
    .vc0_cnt(vc0_cnt), .vc1_cnt(vc1_cnt),
    .arb_idle(arb_idle)
  );

  always #5 clk = ~clk;

  // One clock: present queue heads at negedge, capture grants, let the edge happen, retire popped heads.
  task automatic step();
    @(negedge clk);
    vc0_empty = (q0.size() == 0);
    vc1_empty = (q1.size() == 0);
    vc0_data  = (q0.size() != 0) ? q0[0] : '0;
    vc1_data  = (q1.size() != 0) ? q1[0] : '0;
    #1;
    obs_pop0 = vc0_pop;
    obs_pop1 = vc1_pop;
    @(posedge clk);
    #1;
    if (obs_pop0 && q0.size() != 0) void'(q0.pop_front());
    if (obs_pop1 && q1.size() != 0) void'(q1.pop_front());
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_L = 1'b0;
    q0.delete();
    q1.delete();
    vc0_empty = 1'b1; vc1_empty = 1'b1;
    vc0_data = '0; vc1_data = '0;
    d0_af = 1'b0; d1_af = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  task automatic test_reset();
    reset_L = 1'b0; enable = 1'b0;
    vc0_empty = 1'b1; vc1_empty = 1'b1;
    vc0_data = '0; vc1_data = '0;
    d0_af = 1'b0; d1_af = 1'b0;
    #12;
    n_cmp++; if ({d0_push, d1_push} !== 2'b00) begin n_fail++; $display("FAIL rst_push: got %b want 00", {d0_push, d1_push}); end
    n_cmp++; if ({vc0_pop, vc1_pop} !== 2'b00) begin n_fail++; $display("FAIL rst_pop: got %b want 00", {vc0_pop, vc1_pop}); end
    n_cmp++; if ({d0_data, d1_data} !== 12'h000) begin n_fail++; $display("FAIL rst_data: got %h want 000", {d0_data, d1_data}); end
    n_cmp++; if ({vc0_cnt, vc1_cnt} !== 16'h0000) begin n_fail++; $display("FAIL rst_cnt: got %h want 0000", {vc0_cnt, vc1_cnt}); end
    n_cmp++; if (arb_idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle: got %b want 1", arb_idle); end
  endtask

  task automatic test_basic_route();
    do_reset();
    q0.push_back(6'b00_0001);
    q0.push_back(6'b01_0100);
    step();
    n_cmp++; if ({obs_pop1, obs_pop0} !== 2'b01) begin n_fail++; $display("FAIL t1_pop_c1: got %b want 01", {obs_pop1, obs_pop0}); end
    n_cmp++; if ({d1_push, d0_push} !== 2'b01) begin n_fail++; $display("FAIL t1_push_c1: got %b want 01", {d1_push, d0_push}); end
    n_cmp++; if (d0_data !== 6'b00_0001) begin n_fail++; $display("FAIL t1_d0_data: got %b want 000001", d0_data); end
    step();
    n_cmp++; if ({obs_pop1, obs_pop0} !== 2'b01) begin n_fail++; $display("FAIL t1_pop_c2: got %b want 01", {obs_pop1, obs_pop0}); end
    n_cmp++; if ({d1_push, d0_push} !== 2'b10) begin n_fail++; $display("FAIL t1_push_c2: got %b want 10", {d1_push, d0_push}); end
    n_cmp++; if (d1_data !== 6'b01_0100) begin n_fail++; $display("FAIL t1_d1_data: got %b want 010100", d1_data); end
    n_cmp++; if (d0_data !== 6'b00_0001) begin n_fail++; $display("FAIL t1_d0_hold: got %b want 000001", d0_data); end
    n_cmp++; if (vc0_cnt !== 8'd2) begin n_fail++; $display("FAIL t1_vc0_cnt: got %0d want 2", vc0_cnt); end
    n_cmp++; if (arb_idle !== 1'b0) begin n_fail++; $display("FAIL t1_idle_busy: got %b want 0", arb_idle); end
    step();
    n_cmp++; if ({obs_pop1, obs_pop0, d1_push, d0_push} !== 4'b0000) begin n_fail++; $display("FAIL t1_quiet: got %b want 0000", {obs_pop1, obs_pop0, d1_push, d0_push}); end
    n_cmp++; if (arb_idle !== 1'b1) begin n_fail++; $display("FAIL t1_idle: got %b want 1", arb_idle); end
  endtask

  task automatic test_weighted_rr();
    int exp_g[20] = '{0,0,0,0,1,0,0,0,0,1,0,0,1,1,1,1,1,1,1,1};
    int i0 = 1;
    int i1 = 1;
    logic [BW-1:0] exp_w;
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      q0.push_back(6'(i));
      q1.push_back(6'b10_0000 | 6'(i));
    end
    for (int s = 0; s < 20; s++) begin
      step();
      if (exp_g[s] == 1) begin exp_w = 6'b10_0000 | 6'(i1); i1++; end
      else begin exp_w = 6'(i0); i0++; end
      n_cmp++; if ({obs_pop1, obs_pop0} !== ((exp_g[s] == 1) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL t2_grant[%0d]: got %b want vc%0d", s, {obs_pop1, obs_pop0}, exp_g[s]); end
      n_cmp++; if ({d0_push, d0_data} !== {1'b1, exp_w}) begin n_fail++; $display("FAIL t2_d0[%0d]: got %b/%b want 1/%b", s, d0_push, d0_data, exp_w); end
    end
    n_cmp++; if ({vc0_cnt, vc1_cnt} !== {8'd10, 8'd10}) begin n_fail++; $display("FAIL t2_cnt: got %0d/%0d want 10/10", vc0_cnt, vc1_cnt); end
  endtask

  task automatic test_almost_full_block();
    do_reset();
    d1_af = 1'b1;
    q0.push_back(6'b01_0000);
    q1.push_back(6'b10_0001);
    q1.push_back(6'b10_0010);
    q1.push_back(6'b10_0011);
    for (int s = 0; s < 3; s++) begin
      step();
      n_cmp++; if ({obs_pop1, obs_pop0} !== 2'b10) begin n_fail++; $display("FAIL t3_blocked[%0d]: got %b want 10", s, {obs_pop1, obs_pop0}); end
      n_cmp++; if ({d0_push, d0_data} !== {1'b1, 6'b10_0001 + 6'(s)}) begin n_fail++; $display("FAIL t3_d0[%0d]: got %b/%b", s, d0_push, d0_data); end
    end
    d1_af = 1'b0;
    step();
    n_cmp++; if ({obs_pop1, obs_pop0} !== 2'b01) begin n_fail++; $display("FAIL t3_unblock: got %b want 01", {obs_pop1, obs_pop0}); end
    n_cmp++; if ({d1_push, d1_data} !== {1'b1, 6'b01_0000}) begin n_fail++; $display("FAIL t3_d1: got %b/%b want 1/010000", d1_push, d1_data); end
  endtask

  task automatic test_enable_pause();
    do_reset();
    for (int i = 1; i <= 5; i++) q0.push_back(6'(i));
    for (int i = 1; i <= 3; i++) q1.push_back(6'b10_0000 | 6'(i));
    step();
    step();
    enable = 1'b0;
    n_cmp++; if ({d0_push, d0_data} !== {1'b1, 6'd2}) begin n_fail++; $display("FAIL t4_inflight: got %b/%b want 1/000010", d0_push, d0_data); end
    for (int s = 0; s < 3; s++) begin
      step();
      n_cmp++; if ({obs_pop1, obs_pop0, d1_push, d0_push} !== 4'b0000) begin n_fail++; $display("FAIL t4_paused[%0d]: got %b want 0000", s, {obs_pop1, obs_pop0, d1_push, d0_push}); end
    end
    enable = 1'b1;
    step();
    n_cmp++; if ({obs_pop1, obs_pop0} !== 2'b01) begin n_fail++; $display("FAIL t4_resume1: got %b want 01", {obs_pop1, obs_pop0}); end
    step();
    n_cmp++; if ({obs_pop1, obs_pop0} !== 2'b01) begin n_fail++; $display("FAIL t4_resume2: got %b want 01", {obs_pop1, obs_pop0}); end
    step();
    n_cmp++; if ({obs_pop1, obs_pop0} !== 2'b10) begin n_fail++; $display("FAIL t4_credit_kept: got %b want 10", {obs_pop1, obs_pop0}); end
    n_cmp++; if ({vc0_cnt, vc1_cnt} !== {8'd4, 8'd1}) begin n_fail++; $display("FAIL t4_cnt: got %0d/%0d want 4/1", vc0_cnt, vc1_cnt); end
  endtask

  task automatic test_both_full_idle();
    do_reset();
    d0_af = 1'b1; d1_af = 1'b1;
    q0.push_back(6'b00_0001);
    q1.push_back(6'b11_0000);
    for (int s = 0; s < 3; s++) begin
      step();
      n_cmp++; if ({obs_pop1, obs_pop0, d1_push, d0_push, arb_idle} !== 5'b00000) begin n_fail++; $display("FAIL t5_stall[%0d]: got %b want 00000", s, {obs_pop1, obs_pop0, d1_push, d0_push, arb_idle}); end
    end
    d0_af = 1'b0; d1_af = 1'b0;
    step();
    n_cmp++; if ({obs_pop1, obs_pop0} !== 2'b01) begin n_fail++; $display("FAIL t5_drain0: got %b want 01", {obs_pop1, obs_pop0}); end
    step();
    n_cmp++; if ({obs_pop1, obs_pop0} !== 2'b10) begin n_fail++; $display("FAIL t5_drain1: got %b want 10", {obs_pop1, obs_pop0}); end
    n_cmp++; if ({d1_push, d1_data, arb_idle} !== {1'b1, 6'b11_0000, 1'b0}) begin n_fail++; $display("FAIL t5_lastpush: got %b/%b/%b", d1_push, d1_data, arb_idle); end
    step();
    n_cmp++; if ({d1_push, d0_push, arb_idle} !== 3'b001) begin n_fail++; $display("FAIL t5_idle: got %b want 001", {d1_push, d0_push, arb_idle}); end
  endtask

  task automatic test_cnt_wrap_async_reset();
    do_reset();
    for (int i = 0; i < 256; i++) q1.push_back(6'b10_0000);
    for (int s = 0; s < 256; s++) begin
      step();
      if (s == 254) begin
        n_cmp++; if (vc1_cnt !== 8'd255) begin n_fail++; $display("FAIL t6_cnt255: got %0d want 255", vc1_cnt); end
      end
    end
    n_cmp++; if (vc1_cnt !== 8'd0) begin n_fail++; $display("FAIL t6_wrap: got %0d want 0", vc1_cnt); end
    q1.push_back(6'b10_0101);
    q1.push_back(6'b10_0110);
    step();
    n_cmp++; if ({vc1_cnt, d0_push} !== {8'd1, 1'b1}) begin n_fail++; $display("FAIL t6_prereset: got %0d/%b want 1/1", vc1_cnt, d0_push); end
    #2;
    reset_L = 1'b0;
    #1;
    n_cmp++; if ({d0_push, d1_push, vc0_pop, vc1_pop} !== 4'b0000) begin n_fail++; $display("FAIL t6_async_ctl: got %b want 0000", {d0_push, d1_push, vc0_pop, vc1_pop}); end
    n_cmp++; if ({d0_data, d1_data, vc0_cnt, vc1_cnt} !== 28'h0) begin n_fail++; $display("FAIL t6_async_val: got %h want 0", {d0_data, d1_data, vc0_cnt, vc1_cnt}); end
    n_cmp++; if (arb_idle !== 1'b1) begin n_fail++; $display("FAIL t6_async_idle: got %b want 1", arb_idle); end
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic_route();
    test_weighted_rr();
    test_almost_full_block();
    test_enable_pause();
    test_both_full_idle();
    test_cnt_wrap_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
